// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate-block vector sequencer: FSM state
// encoding, gate_in bit positions and the expected-response table.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } gate_state_e;

    // Bit positions of each gate output within gate_in.
    localparam int GATE_BUF  = 0;
    localparam int GATE_NOT  = 1;
    localparam int GATE_AND  = 2;
    localparam int GATE_NAND = 3;
    localparam int GATE_OR   = 4;
    localparam int GATE_NOR  = 5;
    localparam int GATE_XOR  = 6;
    localparam int GATE_XNOR = 7;

    // Expected gate_in for vector v = {A,B}; entry [v].
    localparam logic [3:0][7:0] EXP_TABLE = {8'h95, 8'h59, 8'h5A, 8'hAA};

    // Error counter ceiling: one count per vector at most.
    localparam logic [2:0] ERR_MAX = 3'd4;

endpackage

// File: rtl/gate_expect.sv
// Combinational lookup of the expected gate_in pattern for a vector index.
module gate_expect
    import gate_seq_pkg::*;
(
    input  logic [1:0] v_i,
    output logic [7:0] exp_o
);

    // Table lookup indexed by the current vector.
    always_comb begin
        exp_o = EXP_TABLE[v_i];
    end

endmodule

// File: rtl/gate_vector_seq.sv
// Gate-block tester: walks A/B through vectors 00,01,10,11, lets each settle
// for HOLD_CYCLES cycles, checks the 8 gate outputs for one cycle and counts
// mismatching vectors. Optional error log enabled by GATE_SEQ_ERRLOG_EN.
//
// Handshake: start is a level request sampled only in IDLE/DONE; busy is high
// while a run is in flight; done (with pass/err_cnt) holds until the next
// accepted start or reset. Outputs are registered from the FSM state, so they
// trail the state by one clock: done rises 1+4*(HOLD_CYCLES+1) clocks after
// the edge that samples start.
module gate_vector_seq
    import gate_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        a_out,
    output logic        b_out,
    input  logic [7:0]  gate_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  err_cnt,
`ifdef GATE_SEQ_ERRLOG_EN
    output logic [1:0]  err_vec,
    output logic [7:0]  err_mask,
`endif
    output gate_state_e dbg_state
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    gate_state_e state_q;
    logic [1:0]  v_q;
    logic [7:0]  hold_q;
    logic [2:0]  err_cnt_q;
    logic        a_q, b_q, busy_q, done_q, pass_q;
    logic [7:0]  exp_w;
    logic        mismatch_w;
    logic        accept_w;

    gate_expect u_expect (
        .v_i   (v_q),
        .exp_o (exp_w)
    );

    assign mismatch_w = (gate_in != exp_w);
    assign accept_w   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Sequencer FSM: vector index, settle counter and mismatch count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            v_q       <= 2'd0;
            hold_q    <= 8'd0;
            err_cnt_q <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q   <= ST_APPLY;
                        v_q       <= 2'd0;
                        hold_q    <= 8'd0;
                        err_cnt_q <= 3'd0;
                    end
                end
                ST_APPLY: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q <= ST_CHECK;
                        hold_q  <= 8'd0;
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch_w && (err_cnt_q != ERR_MAX)) begin
                        err_cnt_q <= err_cnt_q + 3'd1;
                    end
                    if (v_q == 2'd3) begin
                        state_q <= ST_DONE;
                    end else begin
                        v_q     <= v_q + 2'd1;
                        state_q <= ST_APPLY;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output stage: registered copies derived from the current FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            a_q    <= v_q[1];
            b_q    <= v_q[0];
            busy_q <= (state_q == ST_APPLY) || (state_q == ST_CHECK);
            done_q <= (state_q == ST_DONE);
            pass_q <= (state_q == ST_DONE) && (err_cnt_q == 3'd0);
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

`ifdef GATE_SEQ_ERRLOG_EN
    logic [1:0] err_vec_q;
    logic [7:0] err_mask_q;

    // Error log: capture vector and differing bits of the first mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vec_q  <= 2'd0;
            err_mask_q <= 8'd0;
        end else if (accept_w) begin
            err_vec_q  <= 2'd0;
            err_mask_q <= 8'd0;
        end else if ((state_q == ST_CHECK) && mismatch_w && (err_cnt_q == 3'd0)) begin
            err_vec_q  <= v_q;
            err_mask_q <= gate_in ^ exp_w;
        end
    end

    assign err_vec  = err_vec_q;
    assign err_mask = err_mask_q;
`else
    // accept_w only feeds the error log; keep it referenced in the base build.
    logic unused_accept_w;
    assign unused_accept_w = accept_w;
`endif

endmodule

// File: tb/tb_gate_vector_seq.sv
// Bench for gate_vector_seq: two instances (HOLD_CYCLES 4 and 1), one selected
// at a time. Each is wired to a behavioural gate block with injectable faults.
module tb_gate_vector_seq;
    import gate_seq_pkg::*;

    localparam int W = 32;  // {done_cycle[31:16], err_cnt[15:13], pass[12], err_vec[11:10], err_mask[9:2], 2'b0}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus state ----------------
    logic       start_r;
    logic       sel;           // 0 -> HOLD 4 instance, 1 -> HOLD 1 instance
    logic [7:0] and_mask;
    logic [7:0] flip [4];

    logic [W-1:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- DUTs and gate models ----------------
    logic a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
    logic [2:0] cnt0, cnt1;
    logic [7:0] gate0, gate1;
    gate_state_e st0, st1;
`ifdef GATE_SEQ_ERRLOG_EN
    logic [1:0] ev0, ev1;
    logic [7:0] em0, em1;
`endif

    function automatic logic [7:0] ideal(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b, ~a, a};
    endfunction

    always_comb begin
        gate0 = (ideal(a0, b0) & and_mask) ^ flip[{a0, b0}];
        gate1 = (ideal(a1, b1) & and_mask) ^ flip[{a1, b1}];
    end

    gate_vector_seq #(.HOLD_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_r && !sel),
        .a_out(a0), .b_out(b0), .gate_in(gate0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(cnt0),
`ifdef GATE_SEQ_ERRLOG_EN
        .err_vec(ev0), .err_mask(em0),
`endif
        .dbg_state(st0)
    );

    gate_vector_seq #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r && sel),
        .a_out(a1), .b_out(b1), .gate_in(gate1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(cnt1),
`ifdef GATE_SEQ_ERRLOG_EN
        .err_vec(ev1), .err_mask(em1),
`endif
        .dbg_state(st1)
    );

    // Selected instance view.
    logic m_a, m_b, m_busy, m_done, m_pass;
    logic [2:0] m_cnt;
    always_comb begin
        m_a    = sel ? a1 : a0;
        m_b    = sel ? b1 : b0;
        m_busy = sel ? busy1 : busy0;
        m_done = sel ? done1 : done0;
        m_pass = sel ? pass1 : pass0;
        m_cnt  = sel ? cnt1 : cnt0;
    end

    function automatic int run_len(input logic s);
        int h;
        h = s ? 1 : 4;
        return 1 + 4 * (h + 1);
    endfunction

    task automatic check(input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, expv);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        logic [W-1:0] e;
        int dcyc, st, k, h;
        if (!rst_n) begin
            done_prev <= 1'b0;
        end else begin
            if (exp_q.size() > 0) begin
                e    = exp_q[0];
                dcyc = int'(e[31:16]);
                st   = dcyc - run_len(sel);
                k    = cyc - st;
                h    = sel ? 1 : 4;
                if (k >= 1 && k < run_len(sel)) begin
                    check("ab_seq", int'({m_a, m_b}), (k - 1) / (h + 1));
                    check("busy_run", int'(m_busy), 1);
                    check("done_early", int'(m_done), 0);
                end
                if (m_done && !done_prev) begin
                    void'(exp_q.pop_front());
                    check("done_cycle", cyc - st, dcyc - st);
                    check("err_cnt", int'(m_cnt), int'(e[15:13]));
                    check("pass", int'(m_pass), int'(e[12]));
                    check("busy_done", int'(m_busy), 0);
`ifdef GATE_SEQ_ERRLOG_EN
                    check("err_vec", int'(sel ? ev1 : ev0), int'(e[11:10]));
                    check("err_mask", int'(sel ? em1 : em0), int'(e[9:2]));
`endif
                end
            end else if (m_done && !done_prev) begin
                check("unexpected_done", 1, 0);
            end
            done_prev <= m_done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_faults(input logic [7:0] am, input logic [7:0] f0, input logic [7:0] f1,
                               input logic [7:0] f2, input logic [7:0] f3);
        and_mask = am;
        flip[0] = f0; flip[1] = f1; flip[2] = f2; flip[3] = f3;
    endtask

    // Issue start and push the predicted outcome for the current gate model.
    task automatic issue_start();
        logic [W-1:0] e;
        logic [7:0] d, emask;
        logic [1:0] evec;
        int cnt, s_cyc;
        cnt = 0; evec = 2'd0; emask = 8'd0;
        for (int v = 0; v < 4; v++) begin
            logic [1:0] vv;
            vv = 2'(v);
            d = ((ideal(vv[1], vv[0]) & and_mask) ^ flip[v]) ^ ideal(vv[1], vv[0]);
            if (d != 8'd0) begin
                if (cnt == 0) begin
                    evec = vv; emask = d;
                end
                cnt++;
            end
        end
        s_cyc = cyc + 1;
        e = {16'(s_cyc + run_len(sel)), 3'(cnt), (cnt == 0), evec, emask, 2'b00};
        exp_q.push_back(e);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic mid_pulse);
        issue_start();
        if (mid_pulse) begin
            repeat (7) @(negedge clk);
            start_r = 1'b1;
            @(negedge clk);
            start_r = 1'b0;
        end
        wait_drain();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, int'(m_a), 0);
        check({tag, "_b"}, int'(m_b), 0);
        check({tag, "_busy"}, int'(m_busy), 0);
        check({tag, "_done"}, int'(m_done), 0);
        check({tag, "_pass"}, int'(m_pass), 0);
        check({tag, "_cnt"}, int'(m_cnt), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] r [4];
        int s_cyc;
        rst_n = 1'b0; start_r = 1'b0; sel = 1'b0;
        load_faults(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run(1'b0);                                              // good gates
        load_faults(8'h00, 8'h00, 8'h00, 8'h00, 8'h00); run(1'b0);  // tied 0
        load_faults(8'hBF, 8'h00, 8'h00, 8'h00, 8'h00); run(1'b0);  // Xor stuck-at-0
        load_faults(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00); run(1'b1);  // start while busy
        load_faults(8'h00, 8'h00, 8'h00, 8'h00, 8'h00); run(1'b0);  // failing run
        load_faults(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00); run(1'b0);  // rerun from DONE

        // Reset during vector 2, then a full run.
        s_cyc = cyc + 1;
        issue_start();
        for (int i = 0; i < 100 && cyc < s_cyc + 12; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(1'b0);

        // Randomized fault patterns.
        for (int n = 0; n < 10; n++) begin
            for (int v = 0; v < 4; v++)
                r[v] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            load_faults(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hFF,
                        r[0], r[1], r[2], r[3]);
            run(1'($urandom_range(0, 1)));
        end

        // Short-hold instance.
        sel = 1'b1;
        @(negedge clk);
        load_faults(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00); run(1'b0);
        for (int n = 0; n < 4; n++) begin
            for (int v = 0; v < 4; v++)
                r[v] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            load_faults(8'hFF, r[0], r[1], r[2], r[3]);
            run(1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_vector_seq.md
GATE_VECTOR_SEQ -- requirements
Module: gate_vector_seq

Interface
REQ-001 SHALL have parameter: HOLD_CYCLES, default 4, settle cycles per vector (legal range 1..255).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: start  input  1  run request; sampled only in IDLE/DONE.
REQ-006 SHALL have port: a_out  output  1  drives gate-block input A.
REQ-007 SHALL have port: b_out  output  1  drives gate-block input B.
REQ-008 SHALL have port: gate_in  input  8  gate outputs; bit0 Buf, 1 Not, 2 And, 3 Nand, 4 Or, 5 Nor, 6 Xor, 7 Xnor.
REQ-009 SHALL have port: busy  output  1  run in progress.
REQ-010 SHALL have port: done  output  1  run complete; held until next start.
REQ-011 SHALL have port: pass  output  1  done and zero mismatches.
REQ-012 SHALL have port: err_cnt  output  3  mismatching vectors in last run (0..4).

Function
REQ-013 SHALL implement FSM states IDLE, APPLY, CHECK, DONE; all outputs registered.
REQ-014 SHALL use vector index v = {A,B}, applied in order 0,1,2,3; a_out=v[1], b_out=v[0].
REQ-015 SHALL, on start=1 in IDLE or DONE, enter APPLY with v=0, clear err_cnt, done and pass, and set busy.
REQ-016 SHALL stay in APPLY exactly HOLD_CYCLES cycles, then enter CHECK.
REQ-017 SHALL, in CHECK (one cycle), compare gate_in against expected: v0 0xAA, v1 0x5A, v2 0x59, v3 0x95; on mismatch, increment err_cnt.
REQ-018 SHALL, from CHECK, go to APPLY with v+1 if v<3, else go to DONE.
REQ-019 SHALL hold a_out/b_out stable through APPLY and CHECK of the same vector.
REQ-020 SHALL, in DONE, set done=1, busy=0, pass=(err_cnt==0), and keep a_out/b_out at the last vector.
REQ-021 SHALL take 1+4*(HOLD_CYCLES+1) cycles from start sampled to done asserted (21 for default).
REQ-022 SHALL ignore start while busy; a start held high in DONE SHALL restart each time it is sampled.
REQ-023 SHALL saturate err_cnt at 4 (no wrap possible by construction).

Reset
REQ-024 SHALL, on rst_n low (asynchronous, including mid-run), force IDLE and all outputs to 0, and zero v and the hold counter.
REQ-025 SHALL resume operation on the first clock edge after rst_n deasserts, awaiting start.

Configuration
REQ-026 SHALL, with GATE_SEQ_ERRLOG_EN defined, add outputs err_vec (2 bits) and err_mask (8 bits = gate_in XOR expected), captured at the first mismatch of a run and cleared on start or reset.
REQ-027 SHALL, without GATE_SEQ_ERRLOG_EN, omit err_vec, err_mask and their logic entirely; all other behaviour is identical.

Structure
REQ-028 SHALL place in package gate_seq_pkg: the FSM state enum, gate_in bit-index constants, and the 4-entry expected-value table.
REQ-029 SHALL implement the expected-value lookup as sub-module gate_expect (combinational, v in, 8-bit expected out).

Verification
REQ-030 SHALL cover: correct gate model, start pulse -> a/b sequence 00,01,10,11, 5 cycles each; done at cycle 21; pass=1; err_cnt=0.
REQ-031 SHALL cover: gate_in tied 0x00 -> err_cnt=4, pass=0; with macro: err_vec=0, err_mask=0xAA.
REQ-032 SHALL cover: Xor stuck-at-0 -> err_cnt=2, pass=0; with macro: err_vec=1, err_mask=0x40.
REQ-033 SHALL cover: rst_n low during v=2 -> all outputs 0 immediately; next start gives a full 21-cycle run.
REQ-034 SHALL cover: start pulsed while busy -> no effect on timing; start in DONE after a failing run -> err_cnt cleared, rerun passes.
REQ-035 SHALL cover: HOLD_CYCLES=1 -> done 9 cycles after start, pass=1 with correct gate model.
